// File: rtl/dmux_pkg.sv
// Shared definitions for the 1-to-4 registered demultiplexer.
package dmux_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 8;
  localparam int NLANES    = 4;

  typedef logic [1:0] lane_sel_t;

  localparam lane_sel_t LANE0 = 2'd0;
  localparam lane_sel_t LANE1 = 2'd1;
  localparam lane_sel_t LANE2 = 2'd2;
  localparam lane_sel_t LANE3 = 2'd3;

  // One-hot set of lanes addressed by a request; broadcast addresses all.
  function automatic logic [NLANES-1:0] lane_targets(input logic bcast, input lane_sel_t sel);
    logic [NLANES-1:0] t;
    t = '0;
    if (bcast) begin
      t = '1;
    end else begin
      case (sel)
        LANE0:   t = 4'b0001;
        LANE1:   t = 4'b0010;
        LANE2:   t = 4'b0100;
        LANE3:   t = 4'b1000;
        default: t = 4'b0000;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/dmux_lane_reg.sv
// One output lane: single-entry holding register, valid flag and a wrapping
// count of completed output handshakes.
module dmux_lane_reg
  import dmux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain = r_valid & ready;

  // Lane can take a word if empty or if its current word leaves this cycle.
  assign free = ~r_valid | ready;

  // Load wins over drain so a lane can stream one word per cycle; data is
  // kept after a drain, only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (load) begin
        r_data  <= din;
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_drain) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dout  = r_data;
  assign valid = r_valid;
  assign cnt   = r_cnt;

endmodule

// File: rtl/dmux4way16_pipe.sv
// Registered 1-to-4 demultiplexer with per-lane holding registers and
// atomic broadcast. Input readiness depends only on lane state and the
// consumers' ready signals, never on in_valid.
module dmux4way16_pipe
  import dmux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [NLANES-1:0] w_ready;
  logic [NLANES-1:0] w_free;
  logic [NLANES-1:0] w_valid;
  logic [NLANES-1:0] w_target;
  logic [NLANES-1:0] w_load;
  logic              w_accept;
  logic [WIDTH-1:0]  w_dout [NLANES];
  logic [CNT_W-1:0]  w_cnt  [NLANES];

  assign w_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

  assign w_target = lane_targets(bcast, sel);

  // Broadcast needs every lane free so it is never partially delivered.
  always_comb begin
    in_ready = bcast ? (&w_free) : w_free[sel];
  end

  assign w_accept = in_valid & in_ready;
  assign w_load   = w_target & {NLANES{w_accept}};

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      dmux_lane_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load[gi]),
        .din   (in),
        .ready (w_ready[gi]),
        .dout  (w_dout[gi]),
        .valid (w_valid[gi]),
        .free  (w_free[gi]),
        .cnt   (w_cnt[gi])
      );
    end
  endgenerate

  assign out0 = w_dout[0];
  assign out1 = w_dout[1];
  assign out2 = w_dout[2];
  assign out3 = w_dout[3];

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out2_valid = w_valid[2];
  assign out3_valid = w_valid[3];

  assign cnt0 = w_cnt[0];
  assign cnt1 = w_cnt[1];
  assign cnt2 = w_cnt[2];
  assign cnt3 = w_cnt[3];

endmodule

// File: tb/tb_dmux4way16_pipe.sv
// Self-checking bench for dmux4way16_pipe: per-lane scoreboard queues are
// filled on input accepts and drained on output handshakes.
module tb_dmux4way16_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic [1:0]  sel;
  logic        bcast;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0, out1, out2, out3;
  logic        out0_valid, out1_valid, out2_valid, out3_valid;
  logic [3:0]  rdy;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;

  logic [15:0] o_data  [4];
  logic        o_valid [4];
  logic [7:0]  o_cnt   [4];

  logic [15:0] sb_q   [4][$];
  logic [15:0] m_last [4];
  logic [7:0]  m_cnt  [4];

  int n_tests;
  int n_fail;

  dmux4way16_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .sel        (sel),
    .bcast      (bcast),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid),
    .out3_valid (out3_valid),
    .out0_ready (rdy[0]),
    .out1_ready (rdy[1]),
    .out2_ready (rdy[2]),
    .out3_ready (rdy[3]),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .cnt3       (cnt3)
  );

  assign o_data[0] = out0;
  assign o_data[1] = out1;
  assign o_data[2] = out2;
  assign o_data[3] = out3;
  assign o_valid[0] = out0_valid;
  assign o_valid[1] = out1_valid;
  assign o_valid[2] = out2_valid;
  assign o_valid[3] = out3_valid;
  assign o_cnt[0] = cnt0;
  assign o_cnt[1] = cnt1;
  assign o_cnt[2] = cnt2;
  assign o_cnt[3] = cnt3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      sb_q[k].delete();
      m_last[k] = 16'h0000;
      m_cnt[k]  = 8'h00;
    end
  endtask

  // Called right after a falling edge with inputs already driven: checks the
  // DUT against the scoreboard, advances the model, then crosses one rising edge.
  task automatic tick();
    logic [3:0] e_free;
    logic       e_ready;
    logic [3:0] tgt;
    #1;
    for (int k = 0; k < 4; k++) e_free[k] = (sb_q[k].size() == 0) | rdy[k];
    e_ready = bcast ? (&e_free) : e_free[sel];
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lane%0d_valid", k), {31'd0, o_valid[k]}, {31'd0, sb_q[k].size() != 0});
      chk($sformatf("lane%0d_data", k), {16'd0, o_data[k]},
          {16'd0, (sb_q[k].size() != 0) ? sb_q[k][0] : m_last[k]});
      chk($sformatf("lane%0d_cnt", k), {24'd0, o_cnt[k]}, {24'd0, m_cnt[k]});
    end
    tgt = bcast ? 4'b1111 : (4'b0001 << sel);
    for (int k = 0; k < 4; k++) begin
      if (sb_q[k].size() != 0 && rdy[k]) begin
        void'(sb_q[k].pop_front());
        m_cnt[k] = m_cnt[k] + 8'd1;
      end
      if (in_valid && e_ready && tgt[k]) begin
        sb_q[k].push_back(in);
        m_last[k] = in;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic b, input logic [1:0] s,
                       input logic [15:0] d, input logic [3:0] r);
    in_valid = v;
    bcast    = b;
    sel      = s;
    in       = d;
    rdy      = r;
  endtask

  initial begin
    logic [7:0] snap_cnt [3];
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single steer to lane 2, then drain.
    drive(1'b1, 1'b0, 2'd2, 16'hBEEF, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 2'd2, 16'h0000, 4'b0000);
    chk("t2_out2", {16'd0, out2}, 32'h0000BEEF);
    chk("t2_out2_valid", {31'd0, out2_valid}, 32'd1);
    chk("t2_out0_valid", {31'd0, out0_valid}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 2'd2, 16'h0000, 4'b0100);
    tick();
    drive(1'b0, 1'b0, 2'd2, 16'h0000, 4'b0000);
    chk("t2_cnt2", {24'd0, cnt2}, 32'd1);
    chk("t2_out2_valid_drained", {31'd0, out2_valid}, 32'd0);
    tick();

    // Asynchronous reset mid-stream while lane 2 holds a word.
    drive(1'b1, 1'b0, 2'd2, 16'h7777, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000);
    chk("t1_pre_out2_valid", {31'd0, out2_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_rst_valid%0d", k), {31'd0, o_valid[k]}, 32'd0);
      chk($sformatf("t1_rst_data%0d", k), {16'd0, o_data[k]}, 32'd0);
      chk($sformatf("t1_rst_cnt%0d", k), {24'd0, o_cnt[k]}, 32'd0);
    end
    chk("t1_rst_in_ready", {31'd0, in_ready}, 32'd1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t1_post_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Backpressure on lane 1, then drain-and-refill in one cycle.
    drive(1'b1, 1'b0, 2'd1, 16'h1111, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 2'd1, 16'h9999, 4'b0000);
    tick();
    chk("t3_out1_held", {16'd0, out1}, 32'h00001111);
    drive(1'b1, 1'b0, 2'd1, 16'h1234, 4'b0010);
    #1 chk("t3_in_ready_refill", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'd1, 16'h0000, 4'b0000);
    chk("t3_out1_new", {16'd0, out1}, 32'h00001234);
    chk("t3_out1_valid", {31'd0, out1_valid}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'd1, 16'h0000, 4'b0010);
    tick();

    // Broadcast blocked by full lane 3, then delivered atomically.
    drive(1'b1, 1'b0, 2'd3, 16'h3333, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 2'd0, 16'hA5A5, 4'b0000);
    tick();
    chk("t4_blocked_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("t4_blocked_out3", {16'd0, out3}, 32'h00003333);
    drive(1'b1, 1'b1, 2'd0, 16'hA5A5, 4'b1000);
    tick();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_bcast_data%0d", k), {16'd0, o_data[k]}, 32'h0000A5A5);
      snap_cnt[k % 3] = o_cnt[k];
    end
    tick();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111);
    tick();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000);
    chk("t4_cnt0", {24'd0, cnt0}, 32'd1);
    chk("t4_cnt2", {24'd0, cnt2}, 32'd1);
    tick();

    // Streaming 300 words on lane 0 from a fresh reset.
    rst = 1'b1;
    #2 model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 2'd0, 16'(i * 7 + 3), 4'b0001);
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 4'b0001);
    tick();
    chk("t5_cnt0_wrap", {24'd0, cnt0}, 32'd44);
    chk("t5_out0_last", {16'd0, out0}, {16'd0, 16'(299 * 7 + 3)});

    // Lanes 0-2 hold data while lane 3 streams.
    drive(1'b1, 1'b0, 2'd0, 16'h1000, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 2'd1, 16'h2000, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 2'd2, 16'h3000, 4'b0000);
    tick();
    for (int k = 0; k < 3; k++) snap_cnt[k] = m_cnt[k];
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 2'd3, 16'(16'hC000 + i), 4'b1000);
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 4'b1000);
    tick();
    chk("t6_out0", {16'd0, out0}, 32'h00001000);
    chk("t6_out1", {16'd0, out1}, 32'h00002000);
    chk("t6_out2", {16'd0, out2}, 32'h00003000);
    chk("t6_valid012", {29'd0, out2_valid, out1_valid, out0_valid}, 32'd7);
    chk("t6_cnt0", {24'd0, cnt0}, {24'd0, snap_cnt[0]});
    chk("t6_cnt1", {24'd0, cnt1}, {24'd0, snap_cnt[1]});
    chk("t6_cnt2", {24'd0, cnt2}, {24'd0, snap_cnt[2]});
    chk("t6_cnt3", {24'd0, cnt3}, 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
